debouncer_multi: RTL
====================

// Module: debouncer_multi
// PURPOSE
//  Parametrised N-channel successor to the single-button debouncer.
//  - Per channel: 2-FF synchroniser, selectable input polarity, debounced level.
//  - Per channel: one-cycle press/release pulses plus long-press (hold) detection.
//  - Sits between the DE-10 Lite KEY/SW pins and the multiplication state machine.
//  - The FSM consumes clean edges, so it needs no edge detectors of its own.
// PARAMETERS
//  NUM_CH           4       number of independent button channels
//  DEBOUNCE_CYCLES  500000  consecutive mismatching cycles before the level updates (>=1; 10 ms @ 50 MHz)
//  HOLD_CYCLES      0       cycles pressed before hold_pulse fires; 0 disables hold logic
//  ACTIVE_LOW       1       1: raw pin low = pressed; 0: raw pin high = pressed
//  (local) CNT_W  = $clog2(DEBOUNCE_CYCLES+1)
//  (local) HOLD_W = $clog2(HOLD_CYCLES+1), min 1
// PORTS
//  clk            in   1       50 MHz system clock; only clock
//  rst            in   1       synchronous, active-high reset
//  btn            in   NUM_CH  raw asynchronous button pins
//  level          out  NUM_CH  debounced state, 1 = pressed (polarity normalised)
//  press_pulse    out  NUM_CH  1-cycle pulse on debounced 0->1
//  release_pulse  out  NUM_CH  1-cycle pulse on debounced 1->0
//  hold_pulse     out  NUM_CH  1-cycle pulse when press reaches HOLD_CYCLES
//  held           out  NUM_CH  high from hold_pulse until release
// BEHAVIOUR
//  - All channels are identical and fully independent; per-channel description follows.
//  - Reset (rst=1 at posedge):
//    - sync0/sync1 load the inactive pin level (ACTIVE_LOW ? 1 : 0).
//    - level, all pulses, held, debounce cnt and hold cnt all go to 0.
//  - Synchroniser: sync0<=btn; sync1<=sync0; p = sync1 ^ ACTIVE_LOW (p=1 means pressed).
//  - Debounce at each posedge, when not in reset:
//    - If p==level: cnt<=0.
//    - Else if cnt==DEBOUNCE_CYCLES-1: level<=p; cnt<=0.
//    - Else: cnt<=cnt+1.
//  - Latency: pin change sampled at edge k sets level at edge k+1+DEBOUNCE_CYCLES,
//    provided p stays changed throughout.
//  - Glitch rejection: any bounce back to level before the count completes clears cnt.
//    A pulse shorter than DEBOUNCE_CYCLES cycles never reaches level.
//  - Pulses are registered on the same edge that level updates.
//    - press_pulse=1 for exactly one cycle when level goes 0->1.
//    - release_pulse=1 for exactly one cycle when level goes 1->0.
//    - Both are 0 in all other cycles; both never fire together on one channel.
//  - Hold logic (HOLD_CYCLES>0):
//    - hcnt clears while level==0 and on the press edge.
//    - While level==1 and held==0, hcnt increments.
//    - When hcnt==HOLD_CYCLES-1: hold_pulse=1 for one cycle, held<=1, hcnt stops.
//    - First hold_pulse is HOLD_CYCLES cycles after press_pulse.
//    - At most one hold_pulse per press; no auto-repeat.
//    - release_pulse edge clears held and hcnt.
//  - HOLD_CYCLES==0: hold_pulse and held are tied to 0; no hold counter is built.
//  - Button already pressed at reset release: treated as a fresh press.
//    - press_pulse fires after 2+DEBOUNCE_CYCLES cycles.
//  - Reset mid-count or mid-hold: all state is abandoned immediately.
//    - No pulse is emitted on the reset edge or on the edge that releases rst.
//  - Counters never wrap: cnt <= DEBOUNCE_CYCLES-1; hcnt <= HOLD_CYCLES-1.
// TESTING (NUM_CH=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, ACTIVE_LOW=1)
//  1. Reset, btn=2'b11 held: level, pulses and held stay 0 for 20 cycles.
//  2. btn[0] 1->0 sampled at edge k, held low: level[0]=1 and press_pulse[0]=1
//     at edge k+5, pulse drops at k+6; channel 1 unaffected.
//  3. btn[0] low 3 cycles, then high (bounce): level[0] stays 0, no pulses.
//     Repeat bounce trains of 1-3 cycles: still no pulses.
//  4. Press held: hold_pulse[0] one cycle at 10 cycles after press_pulse.
//     held[0]=1 until release; release_pulse[0] 5 cycles after pin returns high, held drops.
//  5. Both channels pressed simultaneously: both press_pulse bits fire on the same edge.
//     Release ch1 only: release_pulse=2'b10.
//  6. Assert rst while cnt=2 and again while held=1: all outputs 0 next cycle,
//     no pulse on rst release. Pin still low: press_pulse after 6 cycles.

Source files
------------

// File: rtl/debouncer_multi.sv
// N-channel button conditioner: 2-FF synchroniser, polarity normalisation, debounced
// level, one-cycle press/release pulses and optional long-press (hold) detection.
module debouncer_multi #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 0,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] btn_i,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] press_pulse_o,
  output logic [NUM_CH-1:0] release_pulse_o,
  output logic [NUM_CH-1:0] hold_pulse_o,
  output logic [NUM_CH-1:0] held_o
);

  localparam int   CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int   HOLD_W   = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic PIN_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic             sync0_q, sync1_q;
    logic             pressed;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    assign pressed = sync1_q ^ PIN_IDLE;

    always_comb begin
      level_d   = level_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (pressed != level_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_d   = pressed;
          press_d   = pressed;
          release_d = ~pressed;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sync0_q   <= PIN_IDLE;
        sync1_q   <= PIN_IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync0_q   <= btn_i[ch];
        sync1_q   <= sync0_q;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign level_o[ch]         = level_q;
    assign press_pulse_o[ch]   = press_q;
    assign release_pulse_o[ch] = release_q;

    if (HOLD_CYCLES > 0) begin : g_hold
      logic [HOLD_W-1:0] hcnt_q, hcnt_d;
      logic              held_q, held_d;
      logic              hold_q, hold_d;

      // The release edge wins over a hold that would complete on the same cycle.
      always_comb begin
        hcnt_d = hcnt_q;
        held_d = held_q;
        hold_d = 1'b0;
        if (!level_q || release_d) begin
          hcnt_d = '0;
          held_d = 1'b0;
        end else if (!held_q) begin
          if (hcnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            hold_d = 1'b1;
            held_d = 1'b1;
          end else begin
            hcnt_d = hcnt_q + HOLD_W'(1);
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          hcnt_q <= '0;
          held_q <= 1'b0;
          hold_q <= 1'b0;
        end else begin
          hcnt_q <= hcnt_d;
          held_q <= held_d;
          hold_q <= hold_d;
        end
      end

      assign hold_pulse_o[ch] = hold_q;
      assign held_o[ch]       = held_q;
    end else begin : g_no_hold
      assign hold_pulse_o[ch] = 1'b0;
      assign held_o[ch]       = 1'b0;
    end
  end

endmodule
